pio_bus_ctrl: RTL and testbench

Parametrised PIO bus master for the ISP1362 HC/DC data bus; the next generation of the device-controller-only bus interface. Each transaction is one command-port write followed by 0..MAXW data-port reads or writes. Target (HC or DC) is selected per transaction, and strobe timing is set by parameters. Data is streamed word by word to and from the client instead of through wide packed buffers. It sits between the HC/DC command sequencers and the chip pins.

---
 rtl/d13_pkg.sv | 22 ++
 rtl/pio_int_sync.sv | 34 +++
 rtl/pio_bus_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pio_bus_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d13_pkg.sv
// d13_pkg: shared types and address-bit constants for the ISP1362 PIO bus
// master.
//   pio_state_t   : transaction FSM state encoding (exported on the debug port)
//   PIO_TGT_*     : O_PIO_ADDR[1], selects the host controller or the device
//                   controller
//   PIO_PORT_*    : O_PIO_ADDR[0], selects the command port or the data port
package d13_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_GAP  = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } pio_state_t;

  localparam logic PIO_TGT_HC    = 1'b0;
  localparam logic PIO_TGT_DC    = 1'b1;
  localparam logic PIO_PORT_CMD  = 1'b1;
  localparam logic PIO_PORT_DATA = 1'b0;

endpackage

// File: rtl/pio_int_sync.sv
// pio_int_sync: brings one asynchronous interrupt line into the I_CLK domain
// and flags its rising edges.
//   I_CLK, I_RST : clock, asynchronous active-high reset
//   I_ASYNC      : raw interrupt pin
//   O_LEVEL      : synchronised level (two flops after the pin)
//   O_RISE       : one-cycle pulse when O_LEVEL goes from 0 to 1
module pio_int_sync (
  input  logic I_CLK,
  input  logic I_RST,
  input  logic I_ASYNC,
  output logic O_LEVEL,
  output logic O_RISE
);

  logic meta_q;
  logic sync_q;
  logic sync_d_q;

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      sync_d_q <= 1'b0;
    end else begin
      meta_q   <= I_ASYNC;
      sync_q   <= meta_q;
      sync_d_q <= sync_q;
    end
  end

  assign O_LEVEL = sync_q;
  assign O_RISE  = sync_q & ~sync_d_q;

endmodule

// File: rtl/pio_bus_ctrl.sv
// pio_bus_ctrl: PIO bus master for the ISP1362 HC/DC data bus. A transaction
// is one command-port write followed by 0..MAXW data-port reads or writes,
// each access strobed low for TLOW cycles with TCYC idle cycles after it.
//   I_CLK, I_RST          : clock, asynchronous active-high reset
//   O_PIO_ADDR            : {target, port}; O_PIO_CSF/RDF/WRF active-low strobes
//   IO_PIO_DATA           : bidirectional data, driven only for writes
//   I_INT_HC, I_INT_DC    : async interrupts -> O_INT levels, O_INT_RISE pulses
//   I_START..I_WORDS      : transaction request, latched in IDLE
//   O_WIDX / I_WDATA      : write-word stream
//   O_RVALID/O_RDATA/O_RIDX : read-word stream
//   O_BUSY, O_DONE        : transaction status
//   O_DBG_STATE           : current FSM state
//
// Client handshake: I_START is taken only while O_BUSY=0 (a start in the DONE
// cycle is dropped). The controller presents O_WIDX and captures I_WDATA on
// the cycle before that word's strobe, so I_WDATA must follow O_WIDX
// combinationally while O_BUSY=1. Read words have no back-pressure: the
// client must take O_RDATA/O_RIDX in the single cycle O_RVALID=1.
module pio_bus_ctrl
  import d13_pkg::*;
#(
  parameter int TLOW = 3,
  parameter int TCYC = 15,
  parameter int MAXW = 32,
  parameter int WW   = $clog2(MAXW + 1)
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  output logic [1:0]    O_PIO_ADDR,
  output logic          O_PIO_CSF,
  output logic          O_PIO_RDF,
  output logic          O_PIO_WRF,
  inout  wire  [15:0]   IO_PIO_DATA,
  input  logic          I_INT_HC,
  input  logic          I_INT_DC,
  input  logic          I_START,
  input  logic          I_TGT,
  input  logic          I_READ,
  input  logic [15:0]   I_CMD,
  input  logic [WW-1:0] I_WORDS,
  output logic [WW-1:0] O_WIDX,
  input  logic [15:0]   I_WDATA,
  output logic          O_RVALID,
  output logic [15:0]   O_RDATA,
  output logic [WW-1:0] O_RIDX,
  output logic          O_BUSY,
  output logic          O_DONE,
  output logic [1:0]    O_INT,
  output logic [1:0]    O_INT_RISE,
  output logic [2:0]    O_DBG_STATE
);

  pio_state_t    state, state_n;
  logic [15:0]   cnt;
  logic          last_low, last_gap;
  logic          tgt_q, rd_q, tgt_n;
  logic [WW-1:0] words_q, idx;
  logic [15:0]   bus_q;
  logic          dout_q, dout_n;
  logic [1:0]    addr_q, addr_n;
  logic          csf_q, rdf_q, wrf_q;
  logic          csf_n, rdf_n, wrf_n;
  logic          rvalid_q;
  logic [15:0]   rdata_q;
  logic [WW-1:0] ridx_q;

  assign last_low = (cnt == 16'(TLOW - 1));
  assign last_gap = (cnt == 16'(TCYC - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (I_START) state_n = S_CMD;
      S_CMD:   if (last_low) state_n = S_GAP;
      S_GAP:   if (last_gap) state_n = (idx < words_q) ? S_DATA : S_DONE;
      S_DATA:  if (last_low) state_n = S_GAP;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Pins are registered from the next state so they are glitch-free yet still
  // change on the same edge as the state; the asynchronous reset forces them
  // inactive immediately.
  assign tgt_n = (state == S_IDLE) ? I_TGT : tgt_q;

  always_comb begin
    addr_n = 2'b00;
    csf_n  = 1'b1;
    rdf_n  = 1'b1;
    wrf_n  = 1'b1;
    dout_n = 1'b0;
    case (state_n)
      S_CMD: begin
        addr_n = {tgt_n, PIO_PORT_CMD};
        csf_n  = 1'b0;
        wrf_n  = 1'b0;
        dout_n = 1'b1;
      end
      S_DATA: begin
        addr_n = {tgt_q, PIO_PORT_DATA};
        csf_n  = 1'b0;
        if (rd_q) begin
          rdf_n = 1'b0;
        end else begin
          wrf_n  = 1'b0;
          dout_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tgt_q    <= PIO_TGT_HC;
      rd_q     <= 1'b0;
      words_q  <= '0;
      idx      <= '0;
      bus_q    <= '0;
      dout_q   <= 1'b0;
      addr_q   <= 2'b00;
      csf_q    <= 1'b1;
      rdf_q    <= 1'b1;
      wrf_q    <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ridx_q   <= '0;
    end else begin
      state    <= state_n;
      addr_q   <= addr_n;
      csf_q    <= csf_n;
      rdf_q    <= rdf_n;
      wrf_q    <= wrf_n;
      dout_q   <= dout_n;
      rvalid_q <= 1'b0;
      // cnt counts cycles spent in the current state.
      if (state_n != state || state == S_IDLE) cnt <= '0;
      else                                     cnt <= cnt + 16'd1;
      if (state == S_IDLE && I_START) begin
        tgt_q   <= I_TGT ? PIO_TGT_DC : PIO_TGT_HC;
        rd_q    <= I_READ;
        bus_q   <= I_CMD;
        words_q <= (I_WORDS > WW'(MAXW)) ? WW'(MAXW) : I_WORDS;
        idx     <= '0;
      end
      // The write word is captured as the strobe starts and held for it.
      if (state == S_GAP && state_n == S_DATA && !rd_q) bus_q <= I_WDATA;
      if (state == S_DATA && last_low) begin
        idx <= idx + WW'(1);
        if (rd_q) begin
          rvalid_q <= 1'b1;
          rdata_q  <= IO_PIO_DATA;
          ridx_q   <= idx;
        end
      end
    end
  end

  assign IO_PIO_DATA = dout_q ? bus_q : 16'hzzzz;

  assign O_PIO_ADDR  = addr_q;
  assign O_PIO_CSF   = csf_q;
  assign O_PIO_RDF   = rdf_q;
  assign O_PIO_WRF   = wrf_q;
  assign O_WIDX      = idx;
  assign O_RVALID    = rvalid_q;
  assign O_RDATA     = rdata_q;
  assign O_RIDX      = ridx_q;
  assign O_BUSY      = (state != S_IDLE);
  assign O_DONE      = (state == S_DONE);
  assign O_DBG_STATE = state;

  pio_int_sync u_sync_hc (
    .I_CLK   (I_CLK),
    .I_RST   (I_RST),
    .I_ASYNC (I_INT_HC),
    .O_LEVEL (O_INT[0]),
    .O_RISE  (O_INT_RISE[0])
  );

  pio_int_sync u_sync_dc (
    .I_CLK   (I_CLK),
    .I_RST   (I_RST),
    .I_ASYNC (I_INT_DC),
    .O_LEVEL (O_INT[1]),
    .O_RISE  (O_INT_RISE[1])
  );

endmodule

// File: tb/tb_pio_bus_ctrl.sv
// tb_pio_bus_ctrl: directed and randomised transactions against a bus-level
// model. A negedge monitor records every chip-select access (address,
// direction, data, strobe length) and the idle gaps between them; each
// transaction is then compared with the access list the protocol demands.
module tb_pio_bus_ctrl;

  localparam int TLOW = 3;
  localparam int TCYC = 15;
  localparam int MAXW = 32;
  localparam int WW   = $clog2(MAXW + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [1:0]    O_PIO_ADDR;
  logic          O_PIO_CSF, O_PIO_RDF, O_PIO_WRF;
  wire  [15:0]   pio_data;
  logic          I_INT_HC = 1'b0, I_INT_DC = 1'b0;
  logic          I_START = 1'b0, I_TGT = 1'b0, I_READ = 1'b0;
  logic [15:0]   I_CMD = '0;
  logic [WW-1:0] I_WORDS = '0;
  logic [WW-1:0] O_WIDX;
  logic [15:0]   I_WDATA;
  logic          O_RVALID;
  logic [15:0]   O_RDATA;
  logic [WW-1:0] O_RIDX;
  logic          O_BUSY, O_DONE;
  logic [1:0]    O_INT, O_INT_RISE;
  logic [2:0]    O_DBG_STATE;

  pio_bus_ctrl #(.TLOW(TLOW), .TCYC(TCYC), .MAXW(MAXW)) dut (
    .I_CLK(clk), .I_RST(rst),
    .O_PIO_ADDR(O_PIO_ADDR), .O_PIO_CSF(O_PIO_CSF), .O_PIO_RDF(O_PIO_RDF),
    .O_PIO_WRF(O_PIO_WRF), .IO_PIO_DATA(pio_data),
    .I_INT_HC(I_INT_HC), .I_INT_DC(I_INT_DC),
    .I_START(I_START), .I_TGT(I_TGT), .I_READ(I_READ), .I_CMD(I_CMD),
    .I_WORDS(I_WORDS), .O_WIDX(O_WIDX), .I_WDATA(I_WDATA),
    .O_RVALID(O_RVALID), .O_RDATA(O_RDATA), .O_RIDX(O_RIDX),
    .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_INT(O_INT), .O_INT_RISE(O_INT_RISE),
    .O_DBG_STATE(O_DBG_STATE)
  );

  // ---------------- bus / client model ----------------
  logic [15:0] wmem [MAXW];
  logic [15:0] rmem [MAXW];
  int          rd_cnt = 0;
  logic [15:0] rd_word;

  assign rd_word = (rd_cnt < MAXW) ? rmem[rd_cnt] : 16'h0000;
  assign I_WDATA = (O_WIDX < MAXW) ? wmem[O_WIDX] : 16'h0000;
  // The chip answers reads; while chip select is high a probe holds the bus at
  // zero, so any stray drive from the master shows up as a wrong value.
  assign pio_data = (O_PIO_RDF == 1'b0) ? rd_word :
                    (O_PIO_CSF ? 16'h0000 : 16'hzzzz);

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q [$];
  int          exp_ridx = 0;
  int          rv_cnt = 0;
  logic [1:0]  acc_addr [$];
  bit          acc_rd [$];
  logic [15:0] acc_data [$];
  int          acc_len [$];
  int          gap_q [$];
  int          rise0 = 0, rise1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  bit          prev_csf = 1'b1, prev_rdf = 1'b1, in_gap = 1'b0;
  bit          cur_rd = 1'b0;
  logic [1:0]  cur_addr = '0;
  logic [15:0] cur_data = '0;
  int          cur_len = 0, gap_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_csf = 1'b1;
      prev_rdf = 1'b1;
      in_gap   = 1'b0;
    end else begin
      if (O_PIO_CSF == 1'b0) begin
        if (prev_csf) begin
          if (in_gap) gap_q.push_back(gap_cnt);
          in_gap   = 1'b0;
          cur_addr = O_PIO_ADDR;
          cur_rd   = (O_PIO_RDF == 1'b0);
          cur_data = cur_rd ? rd_word : pio_data;
          cur_len  = 0;
        end
        cur_len++;
        check("strobes", {O_PIO_RDF, O_PIO_WRF}, cur_rd ? 2'b01 : 2'b10);
        check("addr_hold", O_PIO_ADDR, cur_addr);
        check("bus_val", pio_data, cur_rd ? rd_word : cur_data);
      end else begin
        if (!prev_csf) begin
          acc_addr.push_back(cur_addr);
          acc_rd.push_back(cur_rd);
          acc_data.push_back(cur_data);
          acc_len.push_back(cur_len);
          in_gap  = 1'b1;
          gap_cnt = 0;
        end
        if (in_gap) gap_cnt++;
        check("idle_strobes", {O_PIO_RDF, O_PIO_WRF}, 2'b11);
        check("bus_released", pio_data, 16'h0000);
      end
      if (O_RVALID) begin
        check("rvalid_timing", {prev_rdf, O_PIO_RDF}, 2'b01);
        check("rvalid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("rdata", O_RDATA, exp_q[0]);
          void'(exp_q.pop_front());
        end
        check("ridx", O_RIDX, exp_ridx);
        exp_ridx++;
        rv_cnt++;
      end
      if (!prev_rdf && O_PIO_RDF) rd_cnt++;
      if (O_INT_RISE[0]) rise0++;
      if (O_INT_RISE[1]) rise1++;
      prev_csf = O_PIO_CSF;
      prev_rdf = O_PIO_RDF;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic prep(input bit rd, input int n, input bit fixed);
    for (int i = 0; i < MAXW; i++) begin
      wmem[i] = 16'($urandom);
      rmem[i] = 16'($urandom);
    end
    if (fixed) begin
      wmem[0] = 16'h1234; wmem[1] = 16'h5678;
      rmem[0] = 16'h00A1; rmem[1] = 16'h00A2; rmem[2] = 16'h00A3;
    end
    acc_addr.delete(); acc_rd.delete(); acc_data.delete(); acc_len.delete();
    gap_q.delete(); exp_q.delete();
    in_gap = 1'b0; rd_cnt = 0; exp_ridx = 0; rv_cnt = 0;
    if (rd) for (int i = 0; i < n; i++) exp_q.push_back(rmem[i]);
  endtask

  task automatic run_txn(input logic tgt, input logic rd, input logic [15:0] cmd,
                         input logic [WW-1:0] words, input bit fixed,
                         input bit mid_start, input bit done_start);
    int n, t, na;
    bit seen;
    n = (int'(words) > MAXW) ? MAXW : int'(words);
    prep(rd, n, fixed);
    @(negedge clk);
    I_START = 1'b1; I_TGT = tgt; I_READ = rd; I_CMD = cmd; I_WORDS = words;
    @(negedge clk);
    // Scramble request inputs: the transaction must run on the latched copy.
    I_START = 1'b0; I_TGT = 1'($urandom); I_READ = 1'($urandom);
    I_CMD = 16'($urandom); I_WORDS = WW'($urandom);
    t = 2;
    seen = 1'b0;
    check("start_csf", O_PIO_CSF, 1'b0);
    while (t < 3000) begin
      check("busy", O_BUSY, 1'b1);
      if (O_DONE) begin
        seen = 1'b1;
        break;
      end
      I_START = (mid_start && t == 30);
      if (I_START) I_WORDS = '0;
      @(negedge clk);
      t++;
    end
    check("done_seen", seen, 1'b1);
    check("txn_len", t, (1 + n) * (TLOW + TCYC) + 2);
    I_START = done_start;
    I_WORDS = WW'(1);
    @(negedge clk);
    I_START = 1'b0;
    check("done_pulse", O_DONE, 1'b0);
    check("idle_busy", O_BUSY, 1'b0);
    na = acc_addr.size();
    check("acc_count", na, n + 1);
    for (int i = 0; i < na && i <= n; i++) begin
      check("acc_addr", acc_addr[i], (i == 0) ? {tgt, 1'b1} : {tgt, 1'b0});
      check("acc_dir", acc_rd[i], (i == 0) ? 1'b0 : rd);
      check("acc_len", acc_len[i], TLOW);
      if (i == 0)   check("acc_cmd", acc_data[i], cmd);
      else if (!rd) check("acc_wdata", acc_data[i], wmem[i-1]);
    end
    check("gap_count", gap_q.size(), n);
    foreach (gap_q[i]) check("gap_len", gap_q[i], TCYC);
    check("rvalid_count", rv_cnt, rd ? n : 0);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, lat;
    repeat (3) @(negedge clk);
    check("rst_csf", O_PIO_CSF, 1'b1);
    check("rst_busy", O_BUSY, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_addr", O_PIO_ADDR, 2'b00);
    check("rst_strobes", {O_PIO_CSF, O_PIO_RDF, O_PIO_WRF}, 3'b111);
    check("rst_bus", pio_data, 16'h0000);
    check("rst_status", {O_BUSY, O_DONE, O_RVALID}, 3'b000);
    check("rst_rdata", O_RDATA, 16'h0000);
    check("rst_idx", {O_RIDX, O_WIDX}, '0);
    check("rst_int", {O_INT, O_INT_RISE}, 4'b0000);

    // Directed: write two words to DC, with a start offered in the DONE cycle.
    run_txn(1'b1, 1'b0, 16'h00B4, WW'(2), 1'b1, 1'b0, 1'b1);
    // Directed: read three words from HC.
    run_txn(1'b0, 1'b1, 16'h0027, WW'(3), 1'b1, 1'b0, 1'b0);
    // Command only.
    run_txn(1'b0, 1'b0, 16'h00C3, WW'(0), 1'b0, 1'b0, 1'b0);
    // Over-range word count clamps; a second start mid-transaction is ignored.
    run_txn(1'b1, 1'b1, 16'h0042, WW'(MAXW + 5), 1'b0, 1'b1, 1'b0);

    // Reset during the second data strobe of a write.
    prep(1'b0, 3, 1'b0);
    @(negedge clk);
    I_START = 1'b1; I_TGT = 1'b1; I_READ = 1'b0; I_CMD = 16'h0055; I_WORDS = WW'(3);
    @(negedge clk);
    I_START = 1'b0;
    t = 0;
    while (!(acc_addr.size() == 2 && O_PIO_CSF == 1'b0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("rst_reach", t < 500, 1'b1);
    @(posedge clk);
    #2;
    check("rst_in_strobe", {O_PIO_CSF, O_PIO_WRF}, 2'b00);
    rst = 1'b1;
    #1;
    check("midrst_strobes", {O_PIO_CSF, O_PIO_RDF, O_PIO_WRF}, 3'b111);
    check("midrst_bus", pio_data, 16'h0000);
    check("midrst_busy", O_BUSY, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_done", O_DONE, 1'b0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_idle", {O_DONE, O_BUSY}, 2'b00);
    end
    run_txn(1'b1, 1'b0, 16'h00B4, WW'(2), 1'b0, 1'b0, 1'b0);

    // Randomised back-to-back transactions.
    for (int k = 0; k < 6; k++)
      run_txn(1'($urandom), 1'($urandom), 16'($urandom),
              WW'($urandom_range(0, 6)), 1'b0, 1'b0, 1'b0);

    // Interrupt synchroniser: DC line toggled off the clock edge.
    @(negedge clk);
    rise0 = 0; rise1 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #($urandom_range(1, 4));
      I_INT_DC = 1'b1;
      lat = 0;
      while (lat < 10) begin
        @(posedge clk); #1; lat++;
        if (O_INT[1]) break;
      end
      check("int_rise_lat", (lat >= 2 && lat <= 3), 1'b1);
      repeat ($urandom_range(3, 6)) @(negedge clk);
      #($urandom_range(1, 4));
      I_INT_DC = 1'b0;
      lat = 0;
      while (lat < 10) begin
        @(posedge clk); #1; lat++;
        if (!O_INT[1]) break;
      end
      check("int_fall_lat", (lat >= 2 && lat <= 3), 1'b1);
      repeat ($urandom_range(3, 6)) @(negedge clk);
    end
    @(negedge clk);
    check("int_rise_count", rise1, 4);
    check("int_hc_quiet", {O_INT[0], 8'(rise0)}, 9'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
